// File: rtl/pht_multiport_pkg.sv
// Shared branch-predictor definitions for the pattern history table:
// FSM state encoding, the default counter seed, and a slice helper for
// flattened per-port buses.
package pht_multiport_pkg;

    typedef enum logic {
        PHT_INIT = 1'b0,
        PHT_RUN  = 1'b1
    } pht_state_e;

    // Weakly-not-taken seed for a counter of the given width:
    // 2**(w-1)-1, which is 1 for w=2, 3 for w=3, and 0 for w=1.
    function automatic int pht_weak_nt(input int ctr_width);
        return (1 << (ctr_width - 1)) - 1;
    endfunction

endpackage

// Selects element idx of width w from a flattened per-port vector.
`define PHT_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

// File: rtl/sat_ctr_next.sv
// Combinational saturating counter update. The sum is formed one bit
// wider than the counter, so overflow and underflow appear in the extra
// bit and are clamped rather than wrapping.
module sat_ctr_next #(
    parameter int CTR_WIDTH = 2
) (
    input  logic [CTR_WIDTH-1:0] ctr,
    input  logic                 taken,
    output logic [CTR_WIDTH-1:0] next
);

    localparam logic [CTR_WIDTH:0] ONE = (CTR_WIDTH + 1)'(1);

    logic [CTR_WIDTH:0] wide;
    logic [CTR_WIDTH:0] up;
    logic [CTR_WIDTH:0] down;

    // Increment or decrement, then clamp at all-ones or at zero.
    // NOTE: every signal written in always_comb gets a value on every path.
    // This is why the defaults come first: they prevent inferred latches.
    always_comb begin
        wide = {1'b0, ctr};
        up   = wide + ONE;
        down = wide - ONE;
        next = ctr;
        if (taken) begin
            next = up[CTR_WIDTH] ? {CTR_WIDTH{1'b1}} : up[CTR_WIDTH-1:0];
        end else begin
            next = down[CTR_WIDTH] ? {CTR_WIDTH{1'b0}} : down[CTR_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/sdpram.sv
// Simple dual-port RAM: one synchronous write port and one synchronous
// read port, with one cycle of read latency. A read of the address being
// written in the same cycle returns the old contents.
module sdpram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Synchronous write and registered read.
    // NOTE: the array has no reset so it maps onto block RAM; whatever owns
    // the RAM must initialise it or mask the reads until it is written.
    // NOTE: sequential state always uses non-blocking assignments, so every
    // read in this block sees the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pht_multiport.sv
// Multi-read-port pattern history table. Each read port has its own RAM
// replica, and all replicas share one write port. After reset or flush, a
// sweep writes the weakly-not-taken seed to every entry. During the sweep,
// updates are dropped and the outputs are masked. A same-cycle update to
// an index being read is forwarded to that port on the next cycle.
module pht_multiport
    import pht_multiport_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int CTR_WIDTH  = 2,
    parameter int NUM_RPORT  = 2,
    parameter int INIT_CTR   = pht_weak_nt(CTR_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic [NUM_RPORT*ADDR_WIDTH-1:0] rindex_i,
    output logic [NUM_RPORT*CTR_WIDTH-1:0]  ctr_o,
    output logic [NUM_RPORT-1:0]            taken_o,
    input  logic                            we_i,
    input  logic [ADDR_WIDTH-1:0]           windex_i,
    input  logic                            taken_i,
    input  logic [CTR_WIDTH-1:0]            ctr_i,
    output logic                            ready_o
);

    localparam logic [CTR_WIDTH-1:0]  INIT_VAL = CTR_WIDTH'(INIT_CTR);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    pht_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [CTR_WIDTH-1:0]  ram_wdata;
    logic [CTR_WIDTH-1:0]  next_val;
    logic [CTR_WIDTH-1:0]  rdata [NUM_RPORT];

    logic                  run_wr;
    logic                  mask;
    logic                  mask_q;
    logic [NUM_RPORT-1:0]  hit_d, hit_q;
    logic [CTR_WIDTH-1:0]  fwd_q;

    sat_ctr_next #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_next (
        .ctr   (ctr_i),
        .taken (taken_i),
        .next  (next_val)
    );

    // An update is accepted only in RUN, and only without a flush in the same cycle.
    assign run_wr  = (state_q == PHT_RUN) && we_i && !flush_i;
    assign ready_o = (state_q == PHT_RUN);

    // State and sweep pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PHT_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state, sweep pointer and write-port selection.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ram_we    = 1'b0;
        ram_waddr = windex_i;
        ram_wdata = next_val;
        case (state_q)
            PHT_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = ptr_q;
                ram_wdata = INIT_VAL;
                if (ptr_q == LAST_IDX) begin
                    // The terminal compare ends the sweep; the pointer is parked at 0.
                    state_d = PHT_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            PHT_RUN: begin
                ram_we = run_wr;
            end
            default: begin
                state_d = PHT_INIT;
                ptr_d   = '0;
            end
        endcase
        if (flush_i) begin
            state_d = PHT_INIT;
            ptr_d   = '0;
        end
    end

    // One RAM replica per read port; the write port is broadcast to all of them.
    for (genvar p = 0; p < NUM_RPORT; p++) begin : g_rep
        sdpram #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (CTR_WIDTH)
        ) u_ram (
            .clk   (clk),
            .en    (1'b1),
            .we    (ram_we),
            .waddr (ram_waddr),
            .wdata (ram_wdata),
            .raddr (`PHT_SLICE(rindex_i, p, ADDR_WIDTH)),
            .rdata (rdata[p])
        );
    end

    // Per-port detection of an accepted update that targets the index being read.
    always_comb begin
        hit_d = '0;
        for (int p = 0; p < NUM_RPORT; p++) begin
            hit_d[p] = run_wr && (windex_i == `PHT_SLICE(rindex_i, p, ADDR_WIDTH));
        end
    end

    // Forwarding flags, the forwarded value, and the output mask for reads issued in INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= 1'b1;
            hit_q  <= '0;
            fwd_q  <= INIT_VAL;
        end else begin
            mask_q <= (state_q == PHT_INIT);
            hit_q  <= hit_d;
            fwd_q  <= next_val;
        end
    end

    // The output is masked while sweeping, and for the read that was issued
    // during the last sweep cycle.
    assign mask = (state_q == PHT_INIT) || mask_q;

    // Per-port readout: the seed when masked, else the forwarded value, else the RAM.
    always_comb begin
        ctr_o   = '0;
        taken_o = '0;
        for (int p = 0; p < NUM_RPORT; p++) begin
            if (mask) begin
                `PHT_SLICE(ctr_o, p, CTR_WIDTH) = INIT_VAL;
                taken_o[p] = INIT_VAL[CTR_WIDTH-1];
            end else if (hit_q[p]) begin
                `PHT_SLICE(ctr_o, p, CTR_WIDTH) = fwd_q;
                taken_o[p] = fwd_q[CTR_WIDTH-1];
            end else begin
                `PHT_SLICE(ctr_o, p, CTR_WIDTH) = rdata[p];
                taken_o[p] = rdata[p][CTR_WIDTH-1];
            end
        end
    end

endmodule

// File: doc/pht_multiport.md
Name: pht_multiport

Overview:
- Next-generation pattern history table for the branch predictor. Counter width and read-port count (fetch width) are parametrised.
- Each read port gives a registered saturating-counter readout and a taken prediction; one update port writes back.
- Adds behaviour the single-port table lacks: a self-initialising sweep after reset or flush, read-after-write forwarding, and suppression of updates during the sweep.
- Sits between the fetch-stage index hash and the BPU prediction mux; the update comes from branch resolution.

Parameters:
- ADDR_WIDTH, 8: index width; table depth is 2**ADDR_WIDTH entries.
- CTR_WIDTH, 2: saturating counter width; legal range 1..4.
- NUM_RPORT, 2: number of independent read ports.
- INIT_CTR, 2**(CTR_WIDTH-1)-1: value written to every entry during the sweep (weakly not-taken).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- flush_i  in  1  restart the init sweep (table clear).
- rindex_i  in  NUM_RPORT*ADDR_WIDTH  per-port read index; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- ctr_o  out  NUM_RPORT*CTR_WIDTH  per-port counter value, valid one cycle after its index.
- taken_o  out  NUM_RPORT  per-port prediction = MSB of that port's ctr_o.
- we_i  in  1  update request.
- windex_i  in  ADDR_WIDTH  update index.
- taken_i  in  1  resolved direction.
- ctr_i  in  CTR_WIDTH  counter value observed at prediction time.
- ready_o  out  1  high when the table is initialised and accepting updates.

Behaviour:
- Clock and reset: one clock, clk; reset is rst_n, asynchronous, active low.
- Storage: NUM_RPORT replicas of sdpram (DATA_WIDTH=CTR_WIDTH). The write port is shared across replicas; replica p is read by rindex_i[p]. Read latency is 1 cycle; en is tied high.
- Next-value rule: taken_i=1 gives min(ctr_i+1, 2**CTR_WIDTH-1); taken_i=0 gives max(ctr_i-1, 0). Compute at CTR_WIDTH+1 bits with no wrap.
- FSM has two states, INIT and RUN.
  - Reset entry: state=INIT, sweep pointer=0, ready_o=0.
  - INIT, each cycle: write INIT_CTR to entry [pointer] in all replicas, then pointer+1.
  - Sweep end: when pointer = 2**ADDR_WIDTH-1 is written, the next state is RUN and ready_o=1 from the following cycle. The sweep lasts exactly 2**ADDR_WIDTH cycles after reset release.
  - RUN: the write port carries (we_i, windex_i, next-value).
  - flush_i in any state: next state INIT with pointer=0. A flush on the final sweep cycle still restarts.
  - rst_n low mid-sweep: asynchronous return to INIT, pointer 0.
- Updates in INIT: we_i is ignored and dropped, with no queueing. The producer is responsible for gating on ready_o.
- Outputs in INIT and the first cycle after: ctr_o is forced to INIT_CTR on every port, taken_o accordingly. This masks stale RAM data.
- Forwarding:
  - Capture: if in RUN, we_i=1 and windex_i == rindex_i[p] in cycle t, register hit[p]=1 and the written value.
  - Use: in cycle t+1, ctr_o[p] takes the forwarded value instead of the RAM output. Each port is evaluated independently.
- Simultaneous events:
  - flush_i together with we_i: the write is dropped.
  - All read ports at the same index: all ports return the same value.
  - Update and read at the same index in the same cycle: the updated value is returned (via forwarding).
- Reset values: ctr_o = all ports INIT_CTR; taken_o = MSB of INIT_CTR (0 at defaults); ready_o = 0; forward flags cleared.
- Wrap-around: the sweep pointer is ADDR_WIDTH+1 bits wide, or uses an explicit terminal compare, so it never aliases back to entry 0 silently.

Decomposition:
- In the shared BPU header:
  - pht_state_e enum (PHT_INIT, PHT_RUN);
  - the default weakly-not-taken constant function of CTR_WIDTH;
  - a packing macro for per-port index/counter slices.
- Sub-module sat_ctr_next (parameter CTR_WIDTH; inputs ctr, taken; output next) is the combinational saturating update. It is reused by the BTB and loop predictor.
- sdpram is instantiated unchanged, once per read port via generate.

Test Plan:
- Reset release, defaults (ADDR_WIDTH=8): ready_o stays 0 for 256 cycles then goes 1; a read of every index after that returns ctr_o=2'b01, taken_o=0.
- Saturation: update idx 0x10 with ctr_i=2'b11, taken=1 -> next read gives 2'b11. Update with ctr_i=2'b00, taken=0 -> next read gives 2'b00. Repeat with CTR_WIDTH=3: 7 stays 7, 0 stays 0.
- Forwarding: cycle t has we_i=1, windex=0x2A, ctr_i=01, taken=1, while port0 reads 0x2A and port1 reads 0x2B. At t+1, port0 ctr_o=2'b10 and port1 ctr_o=2'b01.
- Updates during INIT dropped: assert we_i at idx 5 (taken=1, ctr_i=10) during the sweep. After ready_o=1, a read of idx 5 returns 2'b01.
- Flush mid-run: write idx 3 to 2'b11, pulse flush_i. ready_o drops next cycle and stays low 256 cycles; idx 3 then reads 2'b01.
- Async reset mid-sweep: assert rst_n low at sweep cycle 100. ready_o stays 0 and the full 256-cycle sweep reruns after release.
